axi_sram_bridge_mp: RTL and testbench
=====================================

Name: axi_sram_bridge_mp

Overview:
Parametrised successor to the team's single-instruction/single-data SRAM-to-AXI converter. Bridges NPORT SRAM-like request ports to one AXI3 master interface. Port 0 is IF fetch; ports 1..NPORT-1 are data/extra requesters such as a future page-table walker. Supports several outstanding reads per port, one outstanding write, read-after-write hazard blocking and per-port cancel. Sits between the pipeline stages and the AXI crossbar in mycpu_top.

Parameters:
NPORT, 2, number of SRAM-like ports (2..4); port index is used directly as the AXI ID.
RD_OUTST, 2, maximum outstanding reads per port (1..4).
ADDR_W, 32, address width.

Ports:
aclk  in  1  clock
reset  in  1  synchronous, active-high
req  in  NPORT  per-port request valid
wr  in  NPORT  1 = write
size  in  2*NPORT  00 = byte, 01 = half, 10 = word
addr  in  ADDR_W*NPORT  byte address
wstrb  in  4*NPORT  write byte strobes
wdata  in  32*NPORT  write data
cancel  in  NPORT  pulse: discard responses of all in-flight reads on that port
addr_ok  out  NPORT  request accepted this cycle
data_ok  out  NPORT  response valid this cycle
rdata  out  32*NPORT  read data (valid with data_ok)
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, arready  out/in  AXI3 AR channel
rid/rdata_axi/rresp/rlast/rvalid, rready  in/out  AXI3 R channel
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, awready  out/in  AXI3 AW channel
wid/wdata_axi/wstrb_axi/wlast/wvalid, wready  out/in  AXI3 W channel
bid/bresp/bvalid, bready  in/out  AXI3 B channel

Behaviour:
- Constants: arlen = awlen = 0, arburst = awburst = 01, lock/cache/prot = 0, wlast = 1, awid = wid = NPORT-1.
- Reset: every valid/ready/ok output is 0; counters and the hazard register are cleared; a reset mid-transaction abandons it.
- Read request acceptance:
  - addr_ok[p] is combinational.
  - Condition: req[p] & ~wr[p] & AR slot free & outst[p] < RD_OUTST & no RAW hazard & p wins arbitration.
  - Arbitration is fixed priority, highest index first.
  - The accepted request is registered into the AR slot: arvalid = 1 from the next cycle, held with stable payload until arready.
  - arid = p, arsize = size[p].
  - The AR slot frees in the cycle arready & arvalid; a new request may be accepted in that same cycle.
- Per-port read counter outst[p]: +1 on acceptance, -1 on R handshake with rid = p. Simultaneous increment and decrement leaves it unchanged.
- rready is held at 1. An R beat with rid = p drives data_ok[p] = 1 and rdata[p] = rdata_axi in the same cycle, unless that beat is being discarded. rresp is ignored.
- Cancel:
  - On cancel[p], drop[p] is loaded with outst[p] plus any acceptance in the same cycle, minus any response arriving in the same cycle.
  - While drop[p] > 0, each response for p is consumed with data_ok[p] = 0 and drop[p] decrements.
  - New requests on p are still accepted during draining; their responses are delivered normally, because responses are FIFO per ID.
- Write FSM states: W_IDLE -> W_ADDR (awvalid & wvalid) -> W_RESP -> W_IDLE.
  - Acceptance from W_IDLE only: a write port that wins arbitration is accepted (addr_ok = 1), and awvalid and wvalid rise on the next cycle.
  - Each of awvalid/wvalid drops on its own handshake. AW and W may complete in either order or together.
  - Once both have completed, the FSM enters W_RESP with bready = 1.
  - On bvalid the FSM raises data_ok[p] for one cycle and returns to W_IDLE.
- RAW hazard: while the write FSM is not idle, a read whose addr[ADDR_W-1:2] equals the pending write's word address is blocked (addr_ok = 0) until the B handshake completes.
- Reads and writes are arbitrated independently; one read and one write may be accepted in the same cycle on different ports.

Optional Feature:
BRIDGE_STATS_EN.
- Defined: adds outputs stat_rd_cnt[31:0], stat_wr_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_rd_cnt and stat_wr_cnt count completed read and write transactions.
  - stat_stall_cnt counts cycles where some req is high and no addr_ok is high.
  - All three are reset to 0 and saturate at all ones.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package axi_bridge_pkg:
  - AXI constant values (burst INCR, len 0).
  - Size encodings.
  - Write FSM state typedef (W_IDLE, W_ADDR, W_RESP).
- One sub-module, bridge_rd_tracker: per-port outst/drop counters. It is instantiated NPORT times.

Test Plan:
1. NPORT=2: port 0 reads 0x1C000000 with arready = 1 and R after 3 cycles carrying data 0xDEADBEEF -> addr_ok[0] in cycle 0, arid = 0, data_ok[0] with rdata[0] = 0xDEADBEEF in cycle 4.
2. Ports 0 and 1 both request reads in the same cycle -> port 1 is accepted first (arid = 1) and port 0 the next slot. Out-of-order R (rid 0 before rid 1) routes each beat to the correct port.
3. Port 1 writes 0x100 with wstrb = 0011 and AW ready before W -> both handshakes complete. A port 0 read of 0x102 is blocked until bvalid; data_ok[1] pulses once.
4. Port 0 has 2 reads outstanding, then cancel[0], then a third read -> the first two R beats give no data_ok and the third delivers data_ok[0].
5. Port 0 with RD_OUTST = 2 and arready = 1, R withheld -> the third request sees addr_ok[0] = 0 until the first R beat.
6. Assert reset while AW is pending -> the next cycle shows all valids 0 and outst = 0. After reset is released, a fresh read completes normally.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared constants and types for the multi-port SRAM-to-AXI3 bridge.
package axi_bridge_pkg;

  localparam int unsigned ID_W = 4;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_RESP
  } wr_state_e;

  // SRAM size code to AXI AxSIZE; the unused code 11 is treated as a word.
  function automatic logic [2:0] axi_size(input logic [1:0] sz);
    logic [2:0] res;
    case (sz)
      SIZE_BYTE: res = 3'd0;
      SIZE_HALF: res = 3'd1;
      SIZE_WORD: res = 3'd2;
      default:   res = 3'd2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bridge_rd_tracker.sv
// Per-port read bookkeeping: in-flight count and the number of responses still to discard.
module bridge_rd_tracker #(
  parameter int unsigned RdOutst = 2
) (
  input  logic aclk,
  input  logic reset,
  input  logic inc_i,
  input  logic rsp_i,
  input  logic cancel_i,
  output logic full_o,
  output logic deliver_o
);

  localparam int unsigned CntW = 3;

  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            dropping;

  always_comb begin
    dropping = (drop_q != '0);
    outst_d  = outst_q + CntW'(inc_i) - CntW'(rsp_i);
    drop_d   = drop_q;
    // A cancel marks everything still in flight after this cycle's traffic.
    if (cancel_i) begin
      drop_d = outst_d;
    end else if (rsp_i && dropping) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  assign full_o    = (outst_q >= CntW'(RdOutst));
  assign deliver_o = rsp_i & ~dropping;

endmodule

// File: rtl/axi_sram_bridge_mp.sv
// NPORT SRAM-like ports onto one AXI3 master; multiple reads in flight, one write.
// Optional statistics counters are built when BRIDGE_STATS_EN is defined.
module axi_sram_bridge_mp
  import axi_bridge_pkg::*;
#(
  parameter int unsigned NPORT    = 2,
  parameter int unsigned RD_OUTST = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req_i,
  input  logic [NPORT-1:0]        wr_i,
  input  logic [2*NPORT-1:0]      size_i,
  input  logic [ADDR_W*NPORT-1:0] addr_i,
  input  logic [4*NPORT-1:0]      wstrb_i,
  input  logic [32*NPORT-1:0]     wdata_i,
  input  logic [NPORT-1:0]        cancel_i,
  output logic [NPORT-1:0]        addr_ok_o,
  output logic [NPORT-1:0]        data_ok_o,
  output logic [32*NPORT-1:0]     rdata_o,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic [3:0]              arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic [1:0]              arlock_o,
  output logic [3:0]              arcache_o,
  output logic [2:0]              arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [31:0]             rdata_axi_i,
  input  logic [1:0]              rresp_i,
  input  logic                    rlast_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic [3:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic [1:0]              awlock_o,
  output logic [3:0]              awcache_o,
  output logic [2:0]              awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [31:0]             wdata_axi_o,
  output logic [3:0]              wstrb_axi_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
`ifdef BRIDGE_STATS_EN
  ,
  output logic [31:0]             stat_rd_cnt_o,
  output logic [31:0]             stat_wr_cnt_o,
  output logic [31:0]             stat_stall_cnt_o
`endif
);

  logic [ADDR_W-1:0] port_addr [NPORT];
  logic [NPORT-1:0]  rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic [NPORT-1:0]  rd_full, rd_deliver, rsp_hit, hazard, wr_done;
  logic              rd_any, wr_any, ar_free, w_busy;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [1:0]        rd_size, wr_size;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_data;

  logic              arvalid_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arsize_q;

  wr_state_e         w_state_q, w_state_d;
  logic              aw_pend_q, w_pend_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        wsize_q;
  logic [NPORT-1:0]  wport_q;

  logic              unused_axi;
  assign unused_axi = ^{rresp_i, rlast_i, bid_i, bresp_i};

  assign ar_free = ~arvalid_q | arready_i;
  assign w_busy  = (w_state_q != W_IDLE);

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign port_addr[p] = addr_i[p*ADDR_W +: ADDR_W];
    // Word-granular RAW check against the write still in progress.
    assign hazard[p]  = w_busy && (port_addr[p][ADDR_W-1:2] == waddr_q[ADDR_W-1:2]);
    assign rd_cand[p] = req_i[p] & ~wr_i[p] & ar_free & ~rd_full[p] & ~hazard[p];
    assign wr_cand[p] = req_i[p] & wr_i[p] & ~w_busy;
    assign rsp_hit[p] = rvalid_i && (rid_i == ID_W'(p));

    bridge_rd_tracker #(
      .RdOutst (RD_OUTST)
    ) u_rd_tracker (
      .aclk      (aclk),
      .reset     (reset),
      .inc_i     (rd_gnt[p]),
      .rsp_i     (rsp_hit[p]),
      .cancel_i  (cancel_i[p]),
      .full_o    (rd_full[p]),
      .deliver_o (rd_deliver[p])
    );

    assign data_ok_o[p]         = rd_deliver[p] | wr_done[p];
    assign rdata_o[p*32 +: 32] = rdata_axi_i;
  end

  // Fixed priority: later (higher) indices overwrite earlier winners.
  always_comb begin
    rd_gnt  = '0;
    wr_gnt  = '0;
    rd_id   = '0;
    rd_addr = '0;
    rd_size = '0;
    wr_addr = '0;
    wr_size = '0;
    wr_strb = '0;
    wr_data = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (rd_cand[p]) begin
        rd_gnt    = '0;
        rd_gnt[p] = 1'b1;
        rd_id     = ID_W'(p);
        rd_addr   = port_addr[p];
        rd_size   = size_i[2*p +: 2];
      end
      if (wr_cand[p]) begin
        wr_gnt    = '0;
        wr_gnt[p] = 1'b1;
        wr_addr   = port_addr[p];
        wr_size   = size_i[2*p +: 2];
        wr_strb   = wstrb_i[4*p +: 4];
        wr_data   = wdata_i[32*p +: 32];
      end
    end
  end

  assign rd_any    = |rd_gnt;
  assign wr_any    = |wr_gnt;
  assign addr_ok_o = rd_gnt | wr_gnt;

  always_ff @(posedge aclk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
    end else if (rd_any) begin
      arvalid_q <= 1'b1;
      arid_q    <= rd_id;
      araddr_q  <= rd_addr;
      arsize_q  <= axi_size(rd_size);
    end else if (arready_i) begin
      arvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wsize_q   <= '0;
      wport_q   <= '0;
    end else if (wr_any) begin
      aw_pend_q <= 1'b1;
      w_pend_q  <= 1'b1;
      waddr_q   <= wr_addr;
      wdata_q   <= wr_data;
      wstrb_q   <= wr_strb;
      wsize_q   <= axi_size(wr_size);
      wport_q   <= wr_gnt;
    end else begin
      if (awready_i) aw_pend_q <= 1'b0;
      if (wready_i)  w_pend_q  <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (wr_any) w_state_d = W_ADDR;
      W_ADDR: if ((~aw_pend_q | awready_i) & (~w_pend_q | wready_i)) w_state_d = W_RESP;
      W_RESP: if (bvalid_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    bready_o = 1'b0;
    wr_done  = '0;
    case (w_state_q)
      W_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) wr_done = wport_q;
      end
      default: ;
    endcase
  end

  assign arid_o      = arid_q;
  assign araddr_o    = araddr_q;
  assign arlen_o     = AXI_LEN_SINGLE;
  assign arsize_o    = arsize_q;
  assign arburst_o   = AXI_BURST_INCR;
  assign arlock_o    = '0;
  assign arcache_o   = '0;
  assign arprot_o    = '0;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = 1'b1;
  assign awid_o      = ID_W'(NPORT - 1);
  assign awaddr_o    = waddr_q;
  assign awlen_o     = AXI_LEN_SINGLE;
  assign awsize_o    = wsize_q;
  assign awburst_o   = AXI_BURST_INCR;
  assign awlock_o    = '0;
  assign awcache_o   = '0;
  assign awprot_o    = '0;
  assign awvalid_o   = aw_pend_q;
  assign wid_o       = ID_W'(NPORT - 1);
  assign wdata_axi_o = wdata_q;
  assign wstrb_axi_o = wstrb_q;
  assign wlast_o     = 1'b1;
  assign wvalid_o    = w_pend_q;

`ifdef BRIDGE_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

  always_ff @(posedge aclk) begin
    if (reset) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (rvalid_i && stat_rd_q != '1) stat_rd_q <= stat_rd_q + 1'b1;
      if (bvalid_i && bready_o && stat_wr_q != '1) stat_wr_q <= stat_wr_q + 1'b1;
      if ((|req_i) && !(|addr_ok_o) && stat_stall_q != '1) begin
        stat_stall_q <= stat_stall_q + 1'b1;
      end
    end
  end

  assign stat_rd_cnt_o    = stat_rd_q;
  assign stat_wr_cnt_o    = stat_wr_q;
  assign stat_stall_cnt_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_axi_sram_bridge_mp.sv
// Directed scenarios plus a randomized read/cancel run against a queue-based reference model.
module tb_axi_sram_bridge_mp;
  import axi_bridge_pkg::*;

  localparam int unsigned NPORT    = 2;
  localparam int unsigned RD_OUTST = 2;
  localparam int unsigned ADDR_W   = 32;

  logic                    aclk = 1'b0;
  logic                    reset = 1'b1;
  logic [NPORT-1:0]        req, wr, cancel, addr_ok, data_ok;
  logic [2*NPORT-1:0]      size;
  logic [ADDR_W*NPORT-1:0] addr;
  logic [4*NPORT-1:0]      wstrb;
  logic [32*NPORT-1:0]     wdata, rdata;
  logic [ID_W-1:0]         arid, rid, awid, wid, bid;
  logic [ADDR_W-1:0]       araddr, awaddr;
  logic [3:0]              arlen, awlen, arcache, awcache, wstrb_axi;
  logic [2:0]              arsize, awsize, arprot, awprot;
  logic [1:0]              arburst, awburst, arlock, awlock, rresp, bresp;
  logic                    arvalid, arready, rlast, rvalid, rready;
  logic                    awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0]             rdata_axi, wdata_axi;
`ifdef BRIDGE_STATS_EN
  logic [31:0]             stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

  always #5 aclk = ~aclk;

  axi_sram_bridge_mp #(
    .NPORT    (NPORT),
    .RD_OUTST (RD_OUTST),
    .ADDR_W   (ADDR_W)
  ) dut (
    .aclk        (aclk),
    .reset       (reset),
    .req_i       (req),
    .wr_i        (wr),
    .size_i      (size),
    .addr_i      (addr),
    .wstrb_i     (wstrb),
    .wdata_i     (wdata),
    .cancel_i    (cancel),
    .addr_ok_o   (addr_ok),
    .data_ok_o   (data_ok),
    .rdata_o     (rdata),
    .arid_o      (arid),
    .araddr_o    (araddr),
    .arlen_o     (arlen),
    .arsize_o    (arsize),
    .arburst_o   (arburst),
    .arlock_o    (arlock),
    .arcache_o   (arcache),
    .arprot_o    (arprot),
    .arvalid_o   (arvalid),
    .arready_i   (arready),
    .rid_i       (rid),
    .rdata_axi_i (rdata_axi),
    .rresp_i     (rresp),
    .rlast_i     (rlast),
    .rvalid_i    (rvalid),
    .rready_o    (rready),
    .awid_o      (awid),
    .awaddr_o    (awaddr),
    .awlen_o     (awlen),
    .awsize_o    (awsize),
    .awburst_o   (awburst),
    .awlock_o    (awlock),
    .awcache_o   (awcache),
    .awprot_o    (awprot),
    .awvalid_o   (awvalid),
    .awready_i   (awready),
    .wid_o       (wid),
    .wdata_axi_o (wdata_axi),
    .wstrb_axi_o (wstrb_axi),
    .wlast_o     (wlast),
    .wvalid_o    (wvalid),
    .wready_i    (wready),
    .bid_i       (bid),
    .bresp_i     (bresp),
    .bvalid_i    (bvalid),
    .bready_o    (bready)
`ifdef BRIDGE_STATS_EN
    ,
    .stat_rd_cnt_o    (stat_rd_cnt),
    .stat_wr_cnt_o    (stat_wr_cnt),
    .stat_stall_cnt_o (stat_stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    req = '0; wr = '0; cancel = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata_axi = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
  endtask

  task automatic nxt();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    req[p] = 1'b1;
    wr[p]  = 1'b0;
    addr[p*32 +: 32] = a;
    size[2*p +: 2]   = SIZE_WORD;
  endtask

  task automatic rsp(input int id, input logic [31:0] d);
    rvalid = 1'b1;
    rid = ID_W'(id);
    rdata_axi = d;
    rlast = 1'b1;
  endtask

  // Reference model: per-port FIFO of in-flight reads, each flagged when cancelled.
  bit              mq [NPORT][$];
  int              sh [NPORT];
  bit              ar_pend;
  logic [ID_W-1:0] ar_pid;
  logic [31:0]     ar_paddr;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NPORT-1:0] exp_ok, exp_dok;
    bit               free, rv, drain;
    int               rp, c0, q;

    clr();
    addr = '0; size = '0; wstrb = '0; wdata = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk); #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_addr_ok", addr_ok, 0);
    check("rst_data_ok", data_ok, 0);
    check("const_rready", rready, 1);
    check("const_wlast", wlast, 1);
    check("const_ar_misc", {arlock, arcache, arprot}, 0);
    reset = 1'b0;

    // Single read, R three cycles after the AR handshake
    nxt(); clr(); rd(0, 32'h1C00_0000); arready = 1'b1; #1;
    check("t1_addr_ok", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1; #1;
    check("t1_arvalid", arvalid, 1);
    check("t1_arid", arid, 0);
    check("t1_araddr", araddr, 32'h1C00_0000);
    check("t1_arsize", arsize, 3'd2);
    check("t1_arlen_burst", {arlen, arburst}, {4'd0, 2'b01});
    nxt(); clr(); #1;
    check("t1_ar_freed", arvalid, 0);
    nxt(); clr(); #1;
    check("t1_no_early", data_ok, 0);
    nxt(); clr(); rsp(0, 32'hDEAD_BEEF); #1;
    check("t1_data_ok", data_ok, 2'b01);
    check("t1_rdata", rdata[31:0], 32'hDEAD_BEEF);

    // Simultaneous reads: port 1 first, out-of-order R routing
    nxt(); clr(); rd(0, 32'h0000_1000); rd(1, 32'h0000_2000); #1;
    check("t2_prio", addr_ok, 2'b10);
    nxt(); clr(); rd(0, 32'h0000_1000); arready = 1'b1; #1;
    check("t2_arid1", arid, 1);
    check("t2_araddr1", araddr, 32'h0000_2000);
    check("t2_same_cyc", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1; #1;
    check("t2_arid0", arid, 0);
    check("t2_araddr0", araddr, 32'h0000_1000);
    nxt(); clr(); rsp(0, 32'h1111_0000); #1;
    check("t2_r0_ok", data_ok, 2'b01);
    check("t2_r0_data", rdata[31:0], 32'h1111_0000);
    nxt(); clr(); rsp(1, 32'h2222_0001); #1;
    check("t2_r1_ok", data_ok, 2'b10);
    check("t2_r1_data", rdata[63:32], 32'h2222_0001);

    // Write with AW before W, RAW hazard on a read of the same word
    nxt(); clr();
    req[1] = 1'b1; wr[1] = 1'b1; addr[63:32] = 32'h100; size[3:2] = SIZE_HALF;
    wstrb[7:4] = 4'b0011; wdata[63:32] = 32'h0000_A5A5; #1;
    check("t3_wr_acc", addr_ok, 2'b10);
    nxt(); clr(); rd(0, 32'h102); awready = 1'b1; #1;
    check("t3_awvalid", awvalid, 1);
    check("t3_wvalid", wvalid, 1);
    check("t3_awaddr", awaddr, 32'h100);
    check("t3_awid_wid", {awid, wid}, {4'd1, 4'd1});
    check("t3_wstrb", wstrb_axi, 4'b0011);
    check("t3_wdata", wdata_axi, 32'h0000_A5A5);
    check("t3_aw_misc", {awlen, awsize, awburst, awlock, awcache, awprot},
          {4'd0, 3'd1, 2'b01, 2'd0, 4'd0, 3'd0});
    check("t3_raw_blk0", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h102); wready = 1'b1; #1;
    check("t3_aw_done", awvalid, 0);
    check("t3_w_held", wvalid, 1);
    check("t3_raw_blk1", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h102); #1;
    check("t3_w_done", wvalid, 0);
    check("t3_bready", bready, 1);
    check("t3_raw_blk2", addr_ok, 0);
    check("t3_no_dok", data_ok, 0);
    nxt(); clr(); rd(0, 32'h102); bvalid = 1'b1; bid = 4'd1; #1;
    check("t3_b_dok", data_ok, 2'b10);
    check("t3_raw_blk3", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h102); #1;
    check("t3_idle", bready, 0);
    check("t3_dok_once", data_ok, 0);
    check("t3_raw_free", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1; #1;
    check("t3_rd_addr", araddr, 32'h102);
    nxt(); clr(); rsp(0, 32'h0000_5A5A); #1;
    check("t3_rd_ok", data_ok, 2'b01);

    // Outstanding limit, then cancel draining two reads while a third is delivered
    nxt(); clr(); rd(0, 32'h200); arready = 1'b1; #1;
    check("t5_acc0", addr_ok, 2'b01);
    nxt(); clr(); rd(0, 32'h204); arready = 1'b1; #1;
    check("t5_acc1", addr_ok, 2'b01);
    nxt(); clr(); rd(0, 32'h208); arready = 1'b1; #1;
    check("t5_full_a", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h208); #1;
    check("t5_full_b", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h208); cancel[0] = 1'b1; #1;
    check("t4_full_c", addr_ok, 0);
    nxt(); clr(); rd(0, 32'h208); rsp(0, 32'hAAAA_0001); #1;
    check("t4_drop1", data_ok, 0);
    nxt(); clr(); rd(0, 32'h208); arready = 1'b1; #1;
    check("t5_after_r", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1; rsp(0, 32'hAAAA_0002); #1;
    check("t4_drop2", data_ok, 0);
    check("t4_ar3", araddr, 32'h208);
    nxt(); clr(); rsp(0, 32'hAAAA_0003); #1;
    check("t4_third", data_ok, 2'b01);
    check("t4_third_data", rdata[31:0], 32'hAAAA_0003);

    // Reset with two reads in flight and AW pending
    nxt(); clr(); rd(0, 32'h300); arready = 1'b1; #1;
    check("t6_pre0", addr_ok, 2'b01);
    nxt(); clr(); rd(0, 32'h304); arready = 1'b1; #1;
    check("t6_pre1", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1;
    req[1] = 1'b1; wr[1] = 1'b1; addr[63:32] = 32'h400; wstrb[7:4] = 4'hF; #1;
    check("t6_wr_acc", addr_ok, 2'b10);
    nxt(); clr(); #1;
    check("t6_aw_pend", awvalid, 1);
    reset = 1'b1;
    nxt(); clr(); #1;
    check("t6_rst_valids", {arvalid, awvalid, wvalid, bready}, 0);
    check("t6_rst_dok", data_ok, 0);
    reset = 1'b0;
    nxt(); clr(); rd(0, 32'h500); arready = 1'b1; #1;
    check("t6_outst_clr", addr_ok, 2'b01);
    nxt(); clr(); arready = 1'b1; #1;
    check("t6_araddr", araddr, 32'h500);
    nxt(); clr(); rsp(0, 32'h0BAD_F00D); #1;
    check("t6_fresh_ok", data_ok, 2'b01);
    check("t6_fresh_data", rdata[31:0], 32'h0BAD_F00D);
    nxt(); clr(); #1;
    check("t6_idle", arvalid, 0);

    // Randomized reads with cancels; final cycles drain everything
    ar_pend = 1'b0; ar_pid = '0; ar_paddr = '0;
    for (int p = 0; p < NPORT; p++) sh[p] = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      drain = (cyc >= 600);
      nxt(); clr();
      arready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      for (int p = 0; p < NPORT; p++) begin
        req[p] = !drain && ($urandom_range(0, 2) != 0);
        addr[p*32 +: 32] = $urandom;
        size[2*p +: 2] = 2'($urandom_range(0, 2));
        cancel[p] = !drain && ($urandom_range(0, 15) == 0);
      end
      rv = 1'b0;
      rp = 0;
      if (drain || $urandom_range(0, 1) == 1) begin
        c0 = $urandom_range(0, NPORT - 1);
        for (int k = 0; k < NPORT; k++) begin
          q = (c0 + k) % NPORT;
          if (!rv && sh[q] > 0) begin
            rv = 1'b1;
            rp = q;
          end
        end
      end
      if (rv) rsp(rp, $urandom);

      free = !ar_pend || arready;
      exp_ok = '0;
      for (int p = NPORT - 1; p >= 0; p--) begin
        if (exp_ok == '0 && free && req[p] && mq[p].size() < RD_OUTST) exp_ok[p] = 1'b1;
      end
      exp_dok = '0;
      if (rv) exp_dok[rp] = !mq[rp][0];

      #1;
      check("rnd_addr_ok", addr_ok, exp_ok);
      check("rnd_data_ok", data_ok, exp_dok);
      check("rnd_arvalid", arvalid, ar_pend);
      if (ar_pend) begin
        check("rnd_arid", arid, ar_pid);
        check("rnd_araddr", araddr, ar_paddr);
      end
      if (exp_dok != '0) check("rnd_rdata", rdata[rp*32 +: 32], rdata_axi);

      if (rv) begin
        void'(mq[rp].pop_front());
        sh[rp]--;
      end
      if (ar_pend && arready) begin
        sh[ar_pid]++;
        ar_pend = 1'b0;
      end
      for (int p = 0; p < NPORT; p++) begin
        if (exp_ok[p]) begin
          mq[p].push_back(1'b0);
          ar_pend  = 1'b1;
          ar_pid   = ID_W'(p);
          ar_paddr = addr[p*32 +: 32];
        end
      end
      for (int p = 0; p < NPORT; p++) begin
        if (cancel[p]) begin
          for (int i = 0; i < mq[p].size(); i++) mq[p][i] = 1'b1;
        end
      end
    end

    nxt(); clr(); #1;
    check("end_arvalid", arvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
